// File: rtl/sensor_hub_pkg.sv
// Shared definitions for the multi-channel AHB-Lite sensor hub.
// Holds the bus field widths, the hub FSM state encoding, the per-channel
// register map (word offsets within a channel), and the HTRANS/HRESP codes.

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif
`ifndef AHB_MASTER_BITS
`define AHB_MASTER_BITS 4
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

package sensor_hub_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RWAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } hub_state_t;

    // Word offsets (HADDR[11:2]) inside one channel's 4 KB slot.
    localparam logic [9:0] WIN_END  = 10'h03F;  // last word of the data window
    localparam logic [9:0] OFF_EN   = 10'h040;  // byte 0x100
    localparam logic [9:0] OFF_CLR  = 10'h080;  // byte 0x200
    localparam logic [9:0] OFF_STAT = 10'h0C0;  // byte 0x300
    localparam logic [9:0] OFF_MASK = 10'h0C1;  // byte 0x304

    localparam logic [`AHB_RESP_BITS-1:0] RESP_OKAY  = 2'b00;
    localparam logic [`AHB_RESP_BITS-1:0] RESP_ERROR = 2'b01;

    localparam logic [`AHB_TRANS_BITS-1:0] TRANS_IDLE   = 2'b00;
    localparam logic [`AHB_TRANS_BITS-1:0] TRANS_BUSY   = 2'b01;
    localparam logic [`AHB_TRANS_BITS-1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [`AHB_TRANS_BITS-1:0] TRANS_SEQ    = 2'b11;

    localparam logic [`AHB_SIZE_BITS-1:0] SIZE_WORD = 3'b010;

    // True when a word offset decodes to something in the channel map.
    function automatic logic off_mapped(input logic [9:0] off);
        return (off <= WIN_END) || (off == OFF_EN) || (off == OFF_CLR) ||
               (off == OFF_STAT) || (off == OFF_MASK);
    endfunction

endpackage

// File: rtl/sensor_hub_ch_regs.sv
// Per-channel control state of the sensor hub: enable, interrupt mask,
// sticky pending flag and the one-cycle clear pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_en/wr_clr/wr_mask  one-cycle write strobes (data phase)
//   wdata_nz          OR-reduction of HWDATA
//   wdata_b0          HWDATA[0]
//   intr              sensor interrupt, level
//   en, mask, pending register outputs
//   clear             clear pulse, high the cycle after a nonzero CLEAR write

module sensor_ch_regs (
    input  logic clk,
    input  logic rst,
    input  logic wr_en,
    input  logic wr_clr,
    input  logic wr_mask,
    input  logic wdata_nz,
    input  logic wdata_b0,
    input  logic intr,
    output logic en,
    output logic mask,
    output logic pending,
    output logic clear
);

    logic do_clr;
    assign do_clr = wr_clr & wdata_nz;

    always_ff @(posedge clk) begin
        if (rst) begin
            en      <= 1'b0;
            mask    <= 1'b0;
            pending <= 1'b0;
            clear   <= 1'b0;
        end else begin
            clear <= do_clr;
            if (wr_en)   en   <= wdata_nz;
            if (wr_mask) mask <= wdata_b0;
            // A live interrupt beats a simultaneous clear so no event is lost.
            if (intr & en)   pending <= 1'b1;
            else if (do_clr) pending <= 1'b0;
        end
    end

endmodule

// File: rtl/ahb_sensor_hub.sv
// AHB-Lite slave fronting NUM_CH sensor controllers.
// Handshake: an address phase is taken when HSEL & HREADY & HTRANS[1] while
// the slave is not mid-transfer; the data phase completes in the first cycle
// with HREADYOUT=1, and HRDATA/HRESP are only meaningful in that cycle.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   HTRANS..HREADY                 AHB-Lite slave inputs (HMASTLOCK ignored)
//   HRDATA, HREADYOUT, HRESP       AHB-Lite slave outputs
//   sctrl_out, sctrl_interrupt     per-channel sensor data and interrupts
//   sctrl_en, sctrl_clear          per-channel enable and clear pulse
//   sctrl_addr                     shared window word address
//   irq                            OR of masked pending interrupts, registered

`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif
`ifndef AHB_MASTER_BITS
`define AHB_MASTER_BITS 4
`endif
`ifndef AHB_RESP_BITS
`define AHB_RESP_BITS 2
`endif

module ahb_sensor_hub
    import sensor_hub_pkg::*;
#(
    parameter int NUM_CH        = 2,
    parameter int CH_BITS       = 4,
    parameter int READ_WAIT     = 2,
    parameter int FILTER_MASTER = 1,
    parameter logic [`AHB_MASTER_BITS-1:0] MASTER_ID = 4'b0001
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [`AHB_TRANS_BITS-1:0]   HTRANS,
    input  logic [31:0]                  HADDR,
    input  logic                         HWRITE,
    input  logic [`AHB_SIZE_BITS-1:0]    HSIZE,
    input  logic [31:0]                  HWDATA,
    input  logic [`AHB_MASTER_BITS-1:0]  HMASTER,
    input  logic                         HMASTLOCK,
    input  logic                         HSEL,
    input  logic                         HREADY,
    output logic [31:0]                  HRDATA,
    output logic                         HREADYOUT,
    output logic [`AHB_RESP_BITS-1:0]    HRESP,
    input  logic [NUM_CH*32-1:0]         sctrl_out,
    input  logic [NUM_CH-1:0]            sctrl_interrupt,
    output logic [NUM_CH-1:0]            sctrl_en,
    output logic [NUM_CH-1:0]            sctrl_clear,
    output logic [5:0]                   sctrl_addr,
    output logic                         irq
);

    hub_state_t state_q, state_d;

    logic [CH_BITS-1:0] ch_q;
    logic [9:0]         off_q;
    logic               write_q;
    logic [2:0]         wait_cnt_q;
    logic [5:0]         addr_q;
    logic               irq_q;

    logic [NUM_CH-1:0]  en_v, mask_v, pend_v;

    // Address-phase decode.
    logic [CH_BITS-1:0] ch_in;
    logic [9:0]         off_in;
    logic               win_in, err_in, accept;

    assign ch_in  = HADDR[12 +: CH_BITS];
    assign off_in = HADDR[11:2];
    assign win_in = (off_in <= WIN_END);
    assign err_in = ({{(32-CH_BITS){1'b0}}, ch_in} >= 32'(NUM_CH)) ||
                    (HSIZE != SIZE_WORD) ||
                    ((FILTER_MASTER != 0) && (HMASTER != MASTER_ID)) ||
                    !off_mapped(off_in) ||
                    (win_in && HWRITE);

    // DATA and ERR2 are final cycles, so a new address phase may overlap them.
    assign accept = HSEL && HREADY && HTRANS[1] &&
                    (state_q inside {ST_IDLE, ST_DATA, ST_ERR2});

    logic unused_ok;
    assign unused_ok = &{1'b0, HMASTLOCK, HADDR[1:0], HADDR[31:12+CH_BITS], HTRANS[0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            off_q      <= '0;
            write_q    <= 1'b0;
            wait_cnt_q <= 3'd1;
            addr_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ch_q    <= ch_in;
                off_q   <= off_in;
                write_q <= HWRITE;
                if (!err_in && win_in && !HWRITE) addr_q <= off_in[5:0];
            end
            // Counts RWAIT cycles starting at 1 on the first one.
            wait_cnt_q <= (state_q == ST_RWAIT) ? wait_cnt_q + 3'd1 : 3'd1;
            irq_q      <= |(pend_v & mask_v);
        end
    end

    always_comb begin
        state_d   = state_q;
        HREADYOUT = 1'b1;
        HRESP     = RESP_OKAY;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state_q == ST_ERR2) HRESP = RESP_ERROR;
                if (!accept)                               state_d = ST_IDLE;
                else if (err_in)                           state_d = ST_ERR1;
                else if (win_in && !HWRITE && READ_WAIT > 0) state_d = ST_RWAIT;
                else                                       state_d = ST_DATA;
            end
            ST_RWAIT: begin
                HREADYOUT = 1'b0;
                if (wait_cnt_q == 3'(READ_WAIT)) state_d = ST_DATA;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = RESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel mux for the read data path.
    logic        sel_en, sel_mask, sel_pend;
    logic [31:0] win_data;

    always_comb begin
        sel_en   = 1'b0;
        sel_mask = 1'b0;
        sel_pend = 1'b0;
        win_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(ch_q) == c) begin
                sel_en   = en_v[c];
                sel_mask = mask_v[c];
                sel_pend = pend_v[c];
                win_data = sctrl_out[32*c +: 32];
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (state_q == ST_DATA && !write_q) begin
            if (off_q <= WIN_END) begin
                HRDATA = win_data;
            end else begin
                case (off_q)
                    OFF_EN:   HRDATA = {31'b0, sel_en};
                    OFF_STAT: HRDATA = {30'b0, sel_pend, sel_en};
                    OFF_MASK: HRDATA = {31'b0, sel_mask};
                    default:  HRDATA = '0;
                endcase
            end
        end
    end

    // Writes only reach DATA when error-free, so no further qualification.
    logic wr_phase;
    assign wr_phase = (state_q == ST_DATA) && write_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic ch_hit;
        assign ch_hit = wr_phase && (32'(ch_q) == g);

        sensor_ch_regs u_regs (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (ch_hit && off_q == OFF_EN),
            .wr_clr   (ch_hit && off_q == OFF_CLR),
            .wr_mask  (ch_hit && off_q == OFF_MASK),
            .wdata_nz (|HWDATA),
            .wdata_b0 (HWDATA[0]),
            .intr     (sctrl_interrupt[g]),
            .en       (en_v[g]),
            .mask     (mask_v[g]),
            .pending  (pend_v[g]),
            .clear    (sctrl_clear[g])
        );
    end

    assign sctrl_en   = en_v;
    assign sctrl_addr = addr_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_ahb_sensor_hub.sv
// Self-checking bench for ahb_sensor_hub: a directed vector table, a few
// multi-cycle sequences and randomized traffic against a behavioural model.

module tb_ahb_sensor_hub;
    import sensor_hub_pkg::*;

    localparam int NUM_CH    = 2;
    localparam int READ_WAIT = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          HTRANS;
    logic [31:0]         HADDR;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    logic [31:0]         HWDATA;
    logic [3:0]          HMASTER;
    logic                HMASTLOCK;
    logic                HSEL;
    wire                 HREADY;
    wire  [31:0]         HRDATA;
    wire                 HREADYOUT;
    wire  [1:0]          HRESP;
    logic [NUM_CH*32-1:0] sctrl_out;
    logic [NUM_CH-1:0]   sctrl_interrupt;
    wire  [NUM_CH-1:0]   sctrl_en;
    wire  [NUM_CH-1:0]   sctrl_clear;
    wire  [5:0]          sctrl_addr;
    wire                 irq;

    // Single-slave bus: the ready seen by the slave is its own.
    assign HREADY = HREADYOUT;

    always #5 clk = ~clk;

    ahb_sensor_hub #(
        .NUM_CH(NUM_CH), .CH_BITS(4), .READ_WAIT(READ_WAIT),
        .FILTER_MASTER(1), .MASTER_ID(4'b0001)
    ) dut (
        .clk(clk), .rst(rst), .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HWDATA(HWDATA), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK),
        .HSEL(HSEL), .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .sctrl_out(sctrl_out), .sctrl_interrupt(sctrl_interrupt),
        .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear), .sctrl_addr(sctrl_addr),
        .irq(irq)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit mon_on   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [NUM_CH-1:0] en_m, mask_m, pend_m, clear_m;
    logic              irq_m;
    logic [NUM_CH-1:0] req_en_v, req_en_d, req_mask_v, req_mask_d, req_clr;

    // Register effects requested during a data phase land at the next edge.
    always @(posedge clk) begin
        if (rst) begin
            en_m = '0; mask_m = '0; pend_m = '0; clear_m = '0; irq_m = 1'b0;
            req_en_v = '0; req_en_d = '0; req_mask_v = '0; req_mask_d = '0; req_clr = '0;
        end else begin
            irq_m = |(pend_m & mask_m);
            for (int c = 0; c < NUM_CH; c++) begin
                clear_m[c] = req_clr[c];
                if (sctrl_interrupt[c] && en_m[c]) pend_m[c] = 1'b1;
                else if (req_clr[c])               pend_m[c] = 1'b0;
                if (req_en_v[c])   en_m[c]   = req_en_d[c];
                if (req_mask_v[c]) mask_m[c] = req_mask_d[c];
            end
            req_en_v = '0; req_mask_v = '0; req_clr = '0;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_en",    32'(sctrl_en),    32'(en_m));
            check("mon_clear", 32'(sctrl_clear), 32'(clear_m));
            check("mon_irq",   32'(irq),         32'(irq_m));
        end
    end

    function automatic logic [31:0] ad(input int ch, input int off);
        return 32'h4000_0000 | (32'(ch) << 12) | 32'(off);
    endfunction

    function automatic void expect_of(input logic [31:0] a, input logic w,
                                      input logic [2:0] sz, input logic [3:0] m,
                                      output logic e, output int waits,
                                      output logic [31:0] rd);
        int ch, off;
        ch  = int'(a[15:12]);
        off = int'({a[11:2], 2'b00});
        e = (ch >= NUM_CH) || (sz != 3'b010) || (m != 4'd1) ||
            !(off < 'h100 || off == 'h100 || off == 'h200 || off == 'h300 || off == 'h304) ||
            (off < 'h100 && w);
        waits = e ? 1 : ((!w && off < 'h100) ? READ_WAIT : 0);
        rd = '0;
        if (!e && !w) begin
            if (off < 'h100)       rd = sctrl_out[ch*32 +: 32];
            else if (off == 'h100) rd = {31'b0, en_m[ch]};
            else if (off == 'h300) rd = {30'b0, pend_m[ch], en_m[ch]};
            else if (off == 'h304) rd = {31'b0, mask_m[ch]};
        end
    endfunction

    function automatic void model_commit(input logic [31:0] a, input logic w,
                                         input logic [31:0] wd, input logic e);
        int ch, off;
        ch  = int'(a[15:12]);
        off = int'({a[11:2], 2'b00});
        if (!e && w) begin
            if (off == 'h100) begin req_en_v[ch] = 1'b1; req_en_d[ch] = |wd; end
            if (off == 'h200 && wd != 0) req_clr[ch] = 1'b1;
            if (off == 'h304) begin req_mask_v[ch] = 1'b1; req_mask_d[ch] = wd[0]; end
        end
    endfunction

    // ---------------- driver ----------------
    // Called at a negedge; returns at the negedge of the completing cycle.
    task automatic do_xfer(input string name, input logic [31:0] a, input logic w,
                           input logic [31:0] wd, input logic [2:0] sz, input logic [3:0] m,
                           output logic [31:0] rd_o, output logic err_o, output int waits_o);
        logic e; int ew; logic [31:0] erd; bit done;
        HSEL = 1'b1; HTRANS = TRANS_NONSEQ; HADDR = a; HWRITE = w; HSIZE = sz; HMASTER = m;
        @(negedge clk);
        expect_of(a, w, sz, m, e, ew, erd);
        HTRANS = TRANS_IDLE; HSEL = 1'b0; HWDATA = wd;
        model_commit(a, w, wd, e);
        waits_o = 0; done = 0; rd_o = '0; err_o = 1'b0;
        for (int i = 0; i < 16 && !done; i++) begin
            if (HREADYOUT) done = 1;
            else begin
                if (e) check({name, "_err1_resp"}, 32'(HRESP), 32'(RESP_ERROR));
                waits_o++;
                @(negedge clk);
            end
        end
        if (!done) begin
            check({name, "_timeout"}, 32'(0), 32'(1));
        end else begin
            rd_o  = HRDATA;
            err_o = (HRESP == RESP_ERROR);
            check({name, "_waits"}, 32'(waits_o), 32'(ew));
            check({name, "_resp"},  32'(err_o),   32'(e));
            check({name, "_rdata"}, rd_o,         erd);
            if (!e && !w && a[11:8] == 4'h0)
                check({name, "_saddr"}, 32'(sctrl_addr), 32'(a[7:2]));
        end
    endtask

    task automatic count_clear(input int c, output int n);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (sctrl_clear[c]) n++;
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [3:0]  master;
        logic        exp_err;
        int          exp_waits;
        logic [31:0] exp_rdata;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] wd,
                                input logic [2:0] sz, input logic [3:0] m, input logic e,
                                input int wt, input logic [31:0] rd);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = wd; v.size = sz; v.master = m;
        v.exp_err = e; v.exp_waits = wt; v.exp_rdata = rd;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic        er;
        int          wt, n;

        rst = 1'b1; HTRANS = TRANS_IDLE; HADDR = '0; HWRITE = 1'b0; HSIZE = 3'b010;
        HWDATA = '0; HMASTER = 4'd1; HMASTLOCK = 1'b0; HSEL = 1'b0;
        sctrl_interrupt = '0;
        sctrl_out = {32'h1234_5678, 32'hDEAD_BEEF};
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_hreadyout", 32'(HREADYOUT),   32'(1));
        check("rst_hresp",     32'(HRESP),       32'(0));
        check("rst_hrdata",    HRDATA,           32'(0));
        check("rst_en",        32'(sctrl_en),    32'(0));
        check("rst_clear",     32'(sctrl_clear), 32'(0));
        check("rst_saddr",     32'(sctrl_addr),  32'(0));
        check("rst_irq",       32'(irq),         32'(0));
        mon_on = 1;

        // ---- directed vector table ----
        vecs.push_back(mk(ad(1,'h100), 1, 32'h1,    3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(1,'h300), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h1));
        vecs.push_back(mk(ad(1,'h100), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h1));
        vecs.push_back(mk(ad(0,'h300), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(0,'h304), 1, 32'h1,    3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(0,'h304), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h1));
        vecs.push_back(mk(ad(0,'h024), 0, 32'h0,    3'b010, 4'd1, 0, 2, 32'hDEAD_BEEF));
        vecs.push_back(mk(ad(1,'h0FC), 0, 32'h0,    3'b010, 4'd1, 0, 2, 32'h1234_5678));
        vecs.push_back(mk(ad(3,'h100), 1, 32'h1,    3'b010, 4'd1, 1, 1, 32'h0));
        vecs.push_back(mk(ad(0,'h100), 0, 32'h0,    3'b000, 4'd1, 1, 1, 32'h0));
        vecs.push_back(mk(ad(0,'h100), 0, 32'h0,    3'b010, 4'd2, 1, 1, 32'h0));
        vecs.push_back(mk(ad(0,'h010), 1, 32'h7,    3'b010, 4'd1, 1, 1, 32'h0));
        vecs.push_back(mk(ad(0,'h104), 0, 32'h0,    3'b010, 4'd1, 1, 1, 32'h0));
        vecs.push_back(mk(ad(1,'h200), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(1,'h300), 1, 32'hFFFF, 3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(1,'h300), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h1));
        vecs.push_back(mk(ad(0,'h100), 1, 32'h1,    3'b001, 4'd1, 1, 1, 32'h0));
        vecs.push_back(mk(ad(0,'h300), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(1,'h100), 1, 32'h0,    3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(1,'h300), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(1,'h100), 1, 32'h100,  3'b010, 4'd1, 0, 0, 32'h0));
        vecs.push_back(mk(ad(1,'h100), 0, 32'h0,    3'b010, 4'd1, 0, 0, 32'h1));
        vecs.push_back(mk(ad(2,'h100), 0, 32'h0,    3'b010, 4'd1, 1, 1, 32'h0));

        foreach (vecs[i]) begin
            do_xfer($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wr, vecs[i].wdata,
                    vecs[i].size, vecs[i].master, rd, er, wt);
            check($sformatf("tbl%0d_waits", i), 32'(wt), 32'(vecs[i].exp_waits));
            check($sformatf("tbl%0d_err",   i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("tbl%0d_rdata", i), rd,      vecs[i].exp_rdata);
        end
        @(negedge clk);

        // ---- interrupts: ch1 en=1, mask ch1 ----
        do_xfer("irq_mask", ad(1,'h304), 1, 32'h1, 3'b010, 4'd1, rd, er, wt);
        sctrl_interrupt = 2'b10;
        repeat (3) @(negedge clk);
        check("irq_set", 32'(irq), 32'(1));
        do_xfer("irq_clr_hi", ad(1,'h200), 1, 32'h1, 3'b010, 4'd1, rd, er, wt);
        do_xfer("irq_stat_hi", ad(1,'h300), 0, 32'h0, 3'b010, 4'd1, rd, er, wt);
        check("set_wins", rd, 32'h3);
        sctrl_interrupt = 2'b00;
        do_xfer("irq_clr_lo", ad(1,'h200), 1, 32'h1, 3'b010, 4'd1, rd, er, wt);
        do_xfer("irq_stat_lo", ad(1,'h300), 0, 32'h0, 3'b010, 4'd1, rd, er, wt);
        check("pend_cleared", rd, 32'h1);
        repeat (2) @(negedge clk);
        check("irq_cleared", 32'(irq), 32'(0));
        sctrl_interrupt = 2'b10;
        @(negedge clk);
        sctrl_interrupt = 2'b00;
        do_xfer("en_off", ad(1,'h100), 1, 32'h0, 3'b010, 4'd1, rd, er, wt);
        do_xfer("en_off_stat", ad(1,'h300), 0, 32'h0, 3'b010, 4'd1, rd, er, wt);
        check("en_off_keeps_pend", rd, 32'h2);

        // ---- clear pulse width ----
        do_xfer("clr5", ad(0,'h200), 1, 32'h5, 3'b010, 4'd1, rd, er, wt);
        count_clear(0, n);
        check("clr_pulse_one", 32'(n), 32'(1));
        do_xfer("clr0", ad(0,'h200), 1, 32'h0, 3'b010, 4'd1, rd, er, wt);
        count_clear(0, n);
        check("clr_pulse_none", 32'(n), 32'(0));

        // ---- back-to-back write EN then read STATUS ----
        HSEL = 1'b1; HTRANS = TRANS_NONSEQ; HADDR = ad(0,'h100); HWRITE = 1'b1;
        HSIZE = 3'b010; HMASTER = 4'd1;
        @(negedge clk);
        HWDATA = 32'h1;
        model_commit(ad(0,'h100), 1'b1, 32'h1, 1'b0);
        check("b2b_wr_ready", 32'(HREADYOUT), 32'(1));
        HADDR = ad(0,'h300); HWRITE = 1'b0;
        @(negedge clk);
        HTRANS = TRANS_IDLE; HSEL = 1'b0;
        check("b2b_rd_ready", 32'(HREADYOUT), 32'(1));
        check("b2b_rd_data",  HRDATA,         32'h1);

        // ---- BUSY transfer has no effect ----
        @(negedge clk);
        HSEL = 1'b1; HTRANS = TRANS_BUSY; HADDR = ad(0,'h100); HWRITE = 1'b1;
        @(negedge clk);
        HSEL = 1'b0; HTRANS = TRANS_IDLE; HWDATA = 32'h0;
        check("busy_ready", 32'(HREADYOUT), 32'(1));
        check("busy_resp",  32'(HRESP),     32'(0));
        check("busy_rdata", HRDATA,         32'h0);
        repeat (2) @(negedge clk);

        // ---- reset during read wait ----
        HSEL = 1'b1; HTRANS = TRANS_NONSEQ; HADDR = ad(0,'h008); HWRITE = 1'b0;
        @(negedge clk);
        HSEL = 1'b0; HTRANS = TRANS_IDLE;
        check("rw_stall", 32'(HREADYOUT),  32'(0));
        check("rw_saddr", 32'(sctrl_addr), 32'(2));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_rst_ready", 32'(HREADYOUT),   32'(1));
        check("rw_rst_resp",  32'(HRESP),       32'(0));
        check("rw_rst_rdata", HRDATA,           32'h0);
        check("rw_rst_en",    32'(sctrl_en),    32'(0));
        check("rw_rst_clear", 32'(sctrl_clear), 32'(0));
        check("rw_rst_saddr", 32'(sctrl_addr),  32'(0));
        check("rw_rst_irq",   32'(irq),         32'(0));
        @(negedge clk);

        // ---- randomized traffic against the model ----
        for (int t = 0; t < 300; t++) begin
            int ch, sel, off;
            logic w;
            logic [31:0] wd;
            logic [2:0] sz;
            logic [3:0] m;
            if ($urandom_range(0, 3) == 0) sctrl_interrupt = NUM_CH'($urandom());
            for (int c = 0; c < NUM_CH; c++) sctrl_out[32*c +: 32] = $urandom();
            ch  = $urandom_range(0, 2);
            sel = $urandom_range(0, 6);
            case (sel)
                0, 1:    off = 4 * $urandom_range(0, 63);
                2:       off = 'h100;
                3:       off = 'h200;
                4:       off = 'h300;
                5:       off = 'h304;
                default: off = ($urandom_range(0, 1) != 0) ? 'h104 : 'h308;
            endcase
            w  = 1'($urandom_range(0, 1));
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
            sz = ($urandom_range(0, 7) == 0) ? 3'b000 : 3'b010;
            m  = ($urandom_range(0, 7) == 0) ? 4'd2 : 4'd1;
            do_xfer("rnd", ad(ch, off), w, wd, sz, m, rd, er, wt);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        mon_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
